// File: rtl/conv1d_mac_ctrl_if.sv
// Stream bundle for conv1d_mac_ctrl: weight/sample input stream and result output stream.
// master drives s_data/s_valid/m_ready; slave (the controller) drives s_ready/m_data/m_valid.
interface conv1d_mac_ctrl_if #(
  parameter int DW = 14,
  parameter int AW = 28
);
  logic signed [DW-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic signed [AW-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid
  );

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid
  );
endinterface

// File: rtl/conv1d_mac_ctrl.sv
// Valid-mode 1-D convolution sequencer driving one shared MAC: loads M weights, N samples,
// then issues M operand pairs per output. Define CONV_RELU_EN to clamp negative results to 0.
//
// state  | meaning
// LOAD_W | accept filter weights w[0..M-1]
// LOAD_X | accept samples x[0..N-1]
// CLEAR  | clear MAC accumulator, reset tap/return counters
// ISSUE  | M back-to-back (x[o+k], w[k]) pairs to the MAC
// DRAIN  | wait for the M-th product strobe, capture result
// OUTPUT | present y[o] until downstream accepts
module conv1d_mac_ctrl #(
  parameter int N  = 8,
  parameter int M  = 3,
  parameter int DW = 14,
  parameter int AW = 28
) (
  input  logic                 clk,
  input  logic                 reset,
  conv1d_mac_ctrl_if.slave     bus,
  output logic                 mac_reset,
  output logic signed [DW-1:0] mac_a,
  output logic signed [DW-1:0] mac_b,
  output logic                 mac_valid_in,
  input  logic signed [AW-1:0] mac_f,
  input  logic                 mac_valid_out,
  output logic                 busy
);
  localparam int XIW = (N > 1) ? $clog2(N) : 1;
  localparam int WIW = (M > 1) ? $clog2(M) : 1;
  localparam int RW  = $clog2(M + 1);
  // Storage rounded up to a power of two so counters index it at their natural width.
  localparam int XD  = 1 << XIW;
  localparam int WD  = 1 << WIW;

  typedef enum logic [2:0] {
    LOAD_W, LOAD_X, CLEAR, ISSUE, DRAIN, OUTPUT
  } state_t;

  state_t               state_q, state_d;
  logic signed [DW-1:0] w_q [WD];
  logic signed [DW-1:0] w_d [WD];
  logic signed [DW-1:0] x_q [XD];
  logic signed [DW-1:0] x_d [XD];
  logic [WIW-1:0]       wc_q, wc_d, k_q, k_d;
  logic [XIW-1:0]       xc_q, xc_d, o_q, o_d;
  logic [RW-1:0]        rc_q, rc_d;
  logic signed [AW-1:0] m_data_q, m_data_d;
  logic [XIW-1:0]       x_idx;
  logic                 s_ready, m_valid;
  logic signed [AW-1:0] result;

`ifdef CONV_RELU_EN
  assign result = mac_f[AW-1] ? '0 : mac_f;
`else
  assign result = mac_f;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= LOAD_W;
      wc_q     <= '0;
      xc_q     <= '0;
      k_q      <= '0;
      o_q      <= '0;
      rc_q     <= '0;
      m_data_q <= '0;
    end else begin
      state_q  <= state_d;
      wc_q     <= wc_d;
      xc_q     <= xc_d;
      k_q      <= k_d;
      o_q      <= o_d;
      rc_q     <= rc_d;
      m_data_q <= m_data_d;
    end
  end

  always_ff @(posedge clk) begin
    w_q <= w_d;
    x_q <= x_d;
  end

  always_comb begin
    state_d      = state_q;
    wc_d         = wc_q;
    xc_d         = xc_q;
    k_d          = k_q;
    o_d          = o_q;
    rc_d         = rc_q;
    m_data_d     = m_data_q;
    w_d          = w_q;
    x_d          = x_q;
    s_ready      = 1'b0;
    m_valid      = 1'b0;
    mac_reset    = 1'b0;
    mac_valid_in = 1'b0;
    mac_a        = '0;
    mac_b        = '0;
    x_idx        = o_q + XIW'(k_q);

    unique case (state_q)
      LOAD_W: begin
        s_ready = 1'b1;
        if (bus.s_valid) begin
          w_d[wc_q] = bus.s_data;
          if (wc_q == WIW'(M - 1)) begin
            wc_d    = '0;
            state_d = LOAD_X;
          end else begin
            wc_d = wc_q + 1'b1;
          end
        end
      end
      LOAD_X: begin
        s_ready = 1'b1;
        if (bus.s_valid) begin
          x_d[xc_q] = bus.s_data;
          if (xc_q == XIW'(N - 1)) begin
            xc_d    = '0;
            o_d     = '0;
            state_d = CLEAR;
          end else begin
            xc_d = xc_q + 1'b1;
          end
        end
      end
      CLEAR: begin
        mac_reset = 1'b1;
        k_d       = '0;
        rc_d      = '0;
        state_d   = ISSUE;
      end
      ISSUE: begin
        mac_valid_in = 1'b1;
        mac_a        = x_q[x_idx];
        mac_b        = w_q[k_q];
        if (mac_valid_out) rc_d = rc_q + 1'b1;
        if (k_q == WIW'(M - 1)) state_d = DRAIN;
        else                    k_d = k_q + 1'b1;
      end
      DRAIN: begin
        if (mac_valid_out) rc_d = rc_q + 1'b1;
        // mac_f already holds the full sum on the cycle the last product strobe arrives.
        if (rc_d == RW'(M)) begin
          m_data_d = result;
          state_d  = OUTPUT;
        end
      end
      OUTPUT: begin
        m_valid = 1'b1;
        if (bus.m_ready) begin
          if (o_q == XIW'(N - M)) begin
            state_d = LOAD_W;
          end else begin
            o_d     = o_q + 1'b1;
            state_d = CLEAR;
          end
        end
      end
      default: state_d = LOAD_W;
    endcase

    if (!reset) begin
      s_ready      = 1'b0;
      m_valid      = 1'b0;
      mac_reset    = 1'b1;
      mac_valid_in = 1'b0;
      mac_a        = '0;
      mac_b        = '0;
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid;
  assign bus.m_data  = m_data_q;
  assign busy        = reset && !((state_q == LOAD_W) && (wc_q == '0));
endmodule

// File: tb/tb_conv1d_mac_ctrl.sv
// Bench for conv1d_mac_ctrl: behavioural 1-cycle MAC, arithmetic reference model of the
// convolution, directed scenarios plus randomized jobs with input gaps and backpressure.
module tb_conv1d_mac_ctrl;
  localparam int N  = 8;
  localparam int M  = 3;
  localparam int DW = 14;
  localparam int AW = 28;
  localparam int N2 = 4;
  localparam int M2 = 4;

  typedef logic signed [AW-1:0] y_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  conv1d_mac_ctrl_if #(.DW(DW), .AW(AW)) bus ();
  conv1d_mac_ctrl_if #(.DW(DW), .AW(AW)) bus2 ();

  logic                 mac_reset, mac_valid_in, mac_valid_out, busy;
  logic signed [DW-1:0] mac_a, mac_b;
  logic signed [AW-1:0] mac_f;
  logic                 mac_reset2, mac_valid_in2, mac_valid_out2, busy2;
  logic signed [DW-1:0] mac_a2, mac_b2;
  logic signed [AW-1:0] mac_f2;

  conv1d_mac_ctrl #(.N(N), .M(M), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .mac_reset(mac_reset), .mac_a(mac_a), .mac_b(mac_b), .mac_valid_in(mac_valid_in),
    .mac_f(mac_f), .mac_valid_out(mac_valid_out), .busy(busy)
  );

  conv1d_mac_ctrl #(.N(N2), .M(M2), .DW(DW), .AW(AW)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2),
    .mac_reset(mac_reset2), .mac_a(mac_a2), .mac_b(mac_b2), .mac_valid_in(mac_valid_in2),
    .mac_f(mac_f2), .mac_valid_out(mac_valid_out2), .busy(busy2)
  );

  // Behavioural MAC: accumulate on valid_in, product strobe one cycle later.
  always @(posedge clk) begin
    if (mac_reset) begin
      mac_f <= '0; mac_valid_out <= 1'b0;
    end else begin
      mac_valid_out <= mac_valid_in;
      if (mac_valid_in) mac_f <= mac_f + mac_a * mac_b;
    end
    if (mac_reset2) begin
      mac_f2 <= '0; mac_valid_out2 <= 1'b0;
    end else begin
      mac_valid_out2 <= mac_valid_in2;
      if (mac_valid_in2) mac_f2 <= mac_f2 + mac_a2 * mac_b2;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  y_t got_q[$];
  int got_cyc[$];
  y_t got2_q[$];
  int acc_cnt = 0;
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
        got_q.push_back(bus.m_data);
        got_cyc.push_back(cyc);
      end
      if (bus2.m_valid === 1'b1 && bus2.m_ready === 1'b1) got2_q.push_back(bus2.m_data);
      if (bus.s_valid === 1'b1 && bus.s_ready === 1'b1) acc_cnt++;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic ref_job(input int wv[$], input int xv[$], output y_t ys[$]);
    longint acc;
    y_t y;
    ys.delete();
    for (int o = 0; o + wv.size() <= xv.size(); o++) begin
      acc = 0;
      for (int k = 0; k < wv.size(); k++) acc += longint'(xv[o + k]) * longint'(wv[k]);
      y = y_t'(acc);
`ifdef CONV_RELU_EN
      if (y < 0) y = '0;
`endif
      ys.push_back(y);
    end
  endtask

  task automatic load_words(input int words[$], input int gap_mode, input bit sel);
    int i, guard;
    bit toggle;
    logic v, acc;
    i = 0; guard = 0; toggle = 1'b0;
    while (i < words.size() && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
      case (gap_mode)
        1:       begin toggle = ~toggle; v = toggle; end
        2:       v = ($urandom_range(0, 2) != 0);
        default: v = 1'b1;
      endcase
      if (sel) begin bus2.s_valid = v; bus2.s_data = DW'(words[i]); end
      else     begin bus.s_valid  = v; bus.s_data  = DW'(words[i]); end
      @(negedge clk);
      acc = sel ? (bus2.s_valid & bus2.s_ready) : (bus.s_valid & bus.s_ready);
      if (acc === 1'b1) i++;
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus2.s_valid = 1'b0;
    vectors++;
    if (i != words.size()) begin
      miscompares++;
      $display("FAIL load_words: accepted %0d words, required %0d", i, words.size());
    end
  endtask

  task automatic run_job(input int wv[$], input int xv[$], input int gap_mode, input bit rand_ready,
                         output y_t got[$], output int cycs[$]);
    int base, need, budget;
    int words[$];
    base = got_q.size();
    need = xv.size() - wv.size() + 1;
    foreach (wv[i]) words.push_back(wv[i]);
    foreach (xv[i]) words.push_back(xv[i]);
    bus.m_ready = 1'b1;
    load_words(words, gap_mode, 1'b0);
    budget = 0;
    while (got_q.size() < base + need && budget < 5000) begin
      @(posedge clk); #1;
      budget++;
      if (rand_ready) bus.m_ready = ($urandom_range(0, 3) != 0);
    end
    bus.m_ready = 1'b1;
    got.delete(); cycs.delete();
    for (int i = base; i < got_q.size(); i++) begin
      got.push_back(got_q[i]);
      cycs.push_back(got_cyc[i]);
    end
  endtask

  task automatic basic_data(output int wv[$], output int xv[$]);
    wv.delete(); xv.delete();
    for (int i = 1; i <= M; i++) wv.push_back(i);
    for (int i = 1; i <= N; i++) xv.push_back(i);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.s_valid = 1'b0;  bus.s_data = '0;  bus.m_ready = 1'b1;
    bus2.s_valid = 1'b0; bus2.s_data = '0; bus2.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.s_ready !== 1'b0 || bus.m_valid !== 1'b0 || bus.m_data !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: s_ready=%b m_valid=%b m_data=%0d busy=%b, required 0 0 0 0",
               bus.s_ready, bus.m_valid, bus.m_data, busy);
    end
    vectors++;
    if (mac_reset !== 1'b1 || mac_valid_in !== 1'b0 || mac_a !== '0 || mac_b !== '0) begin
      miscompares++;
      $display("FAIL reset_mac: mac_reset=%b valid_in=%b a=%0d b=%0d, required 1 0 0 0",
               mac_reset, mac_valid_in, mac_a, mac_b);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.s_ready !== 1'b1 || busy !== 1'b0 || mac_reset !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: s_ready=%b busy=%b mac_reset=%b, required 1 0 0",
               bus.s_ready, busy, mac_reset);
    end
  endtask

  task automatic test_basic();
    int wv[$], xv[$], cycs[$];
    y_t got[$];
    basic_data(wv, xv);
    run_job(wv, xv, 0, 1'b0, got, cycs);
    vectors++;
    if (got.size() != N - M + 1) begin
      miscompares++;
      $display("FAIL basic_count: got %0d outputs, required %0d", got.size(), N - M + 1);
    end
    for (int o = 0; o < got.size(); o++) begin
      vectors++;
      if (got[o] !== y_t'(6 * o + 14)) begin
        miscompares++;
        $display("FAIL basic_y[%0d]: got %0d, required %0d", o, got[o], 6 * o + 14);
      end
    end
    for (int o = 0; o + 1 < cycs.size(); o++) begin
      vectors++;
      if (cycs[o + 1] - cycs[o] != M + 3) begin
        miscompares++;
        $display("FAIL basic_spacing[%0d]: got %0d cycles, required %0d", o, cycs[o + 1] - cycs[o], M + 3);
      end
    end
    @(negedge clk);
    vectors++;
    if (bus.s_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_idle: s_ready=%b busy=%b, required 1 0", bus.s_ready, busy);
    end
  endtask

  task automatic test_negative();
    int wv[$], xv[$], cycs[$];
    y_t got[$];
    y_t exp_y;
    basic_data(wv, xv);
    foreach (wv[i]) wv[i] = -1;
    run_job(wv, xv, 0, 1'b0, got, cycs);
    vectors++;
    if (got.size() != N - M + 1) begin
      miscompares++;
      $display("FAIL negative_count: got %0d outputs, required %0d", got.size(), N - M + 1);
    end
    for (int o = 0; o < got.size(); o++) begin
`ifdef CONV_RELU_EN
      exp_y = '0;
`else
      exp_y = y_t'(-(3 * o + 6));
`endif
      vectors++;
      if (got[o] !== exp_y) begin
        miscompares++;
        $display("FAIL negative_y[%0d]: got %0d, required %0d", o, got[o], exp_y);
      end
    end
  endtask

  task automatic test_backpressure();
    int wv[$], xv[$], words[$];
    int base, budget;
    basic_data(wv, xv);
    foreach (wv[i]) words.push_back(wv[i]);
    foreach (xv[i]) words.push_back(xv[i]);
    base = got_q.size();
    bus.m_ready = 1'b1;
    load_words(words, 0, 1'b0);
    budget = 0;
    while (got_q.size() < base + 1 && budget < 200) begin @(posedge clk); #1; budget++; end
    bus.m_ready = 1'b0;
    budget = 0;
    @(negedge clk);
    while (bus.m_valid !== 1'b1 && budget < 50) begin @(negedge clk); budget++; end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (bus.m_valid !== 1'b1 || bus.m_data !== y_t'(20) || mac_valid_in !== 1'b0 || bus.s_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall[%0d]: m_valid=%b m_data=%0d mac_valid_in=%b s_ready=%b, required 1 20 0 0",
                 i, bus.m_valid, bus.m_data, mac_valid_in, bus.s_ready);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    budget = 0;
    while (got_q.size() < base + N - M + 1 && budget < 200) begin @(posedge clk); #1; budget++; end
    vectors++;
    if (got_q.size() != base + N - M + 1) begin
      miscompares++;
      $display("FAIL stall_count: got %0d outputs, required %0d", got_q.size() - base, N - M + 1);
    end
    for (int o = 0; base + o < got_q.size(); o++) begin
      vectors++;
      if (got_q[base + o] !== y_t'(6 * o + 14)) begin
        miscompares++;
        $display("FAIL stall_y[%0d]: got %0d, required %0d", o, got_q[base + o], 6 * o + 14);
      end
    end
  endtask

  task automatic test_gaps();
    int wv[$], xv[$], cycs[$];
    int acc0;
    y_t got[$];
    basic_data(wv, xv);
    acc0 = acc_cnt;
    run_job(wv, xv, 1, 1'b0, got, cycs);
    vectors++;
    if (acc_cnt - acc0 != M + N) begin
      miscompares++;
      $display("FAIL gaps_accepted: got %0d words, required %0d", acc_cnt - acc0, M + N);
    end
    vectors++;
    if (got.size() != N - M + 1) begin
      miscompares++;
      $display("FAIL gaps_count: got %0d outputs, required %0d", got.size(), N - M + 1);
    end
    for (int o = 0; o < got.size(); o++) begin
      vectors++;
      if (got[o] !== y_t'(6 * o + 14)) begin
        miscompares++;
        $display("FAIL gaps_y[%0d]: got %0d, required %0d", o, got[o], 6 * o + 14);
      end
    end
  endtask

  task automatic test_reset_mid_issue();
    int wv[$], xv[$], words[$], cycs[$];
    int base, budget;
    y_t got[$], ys[$];
    basic_data(wv, xv);
    foreach (wv[i]) words.push_back(wv[i]);
    foreach (xv[i]) words.push_back(xv[i]);
    base = got_q.size();
    bus.m_ready = 1'b1;
    load_words(words, 0, 1'b0);
    budget = 0;
    while (got_q.size() < base + 2 && budget < 200) begin @(posedge clk); #1; budget++; end
    budget = 0;
    @(negedge clk);
    while (mac_valid_in !== 1'b1 && budget < 20) begin @(negedge clk); budget++; end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (mac_valid_in !== 1'b0 || mac_reset !== 1'b1 || bus.m_valid !== 1'b0 || bus.s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_low: valid_in=%b mac_reset=%b m_valid=%b s_ready=%b, required 0 1 0 0",
               mac_valid_in, mac_reset, bus.m_valid, bus.s_ready);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.m_valid !== 1'b0 || mac_valid_in !== 1'b0 || busy !== 1'b0 || bus.s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_after: m_valid=%b valid_in=%b busy=%b s_ready=%b, required 0 0 0 1",
               bus.m_valid, mac_valid_in, busy, bus.s_ready);
    end
    wv.delete(); xv.delete();
    for (int i = 0; i < M; i++) wv.push_back(int'($urandom_range(0, 200)) - 100);
    for (int i = 0; i < N; i++) xv.push_back(int'($urandom_range(0, 200)) - 100);
    ref_job(wv, xv, ys);
    run_job(wv, xv, 0, 1'b0, got, cycs);
    vectors++;
    if (got.size() != ys.size()) begin
      miscompares++;
      $display("FAIL midreset_count: got %0d outputs, required %0d", got.size(), ys.size());
    end
    for (int o = 0; o < got.size() && o < ys.size(); o++) begin
      vectors++;
      if (got[o] !== ys[o]) begin
        miscompares++;
        $display("FAIL midreset_y[%0d]: got %0d, required %0d", o, got[o], ys[o]);
      end
    end
  endtask

  task automatic test_random();
    int wv[$], xv[$], cycs[$];
    y_t got[$], ys[$];
    for (int j = 0; j < 4; j++) begin
      wv.delete(); xv.delete();
      for (int i = 0; i < M; i++) wv.push_back(int'($urandom_range(0, 16382)) - 8191);
      for (int i = 0; i < N; i++) xv.push_back(int'($urandom_range(0, 16382)) - 8191);
      ref_job(wv, xv, ys);
      run_job(wv, xv, 2, 1'b1, got, cycs);
      vectors++;
      if (got.size() != ys.size()) begin
        miscompares++;
        $display("FAIL random%0d_count: got %0d outputs, required %0d", j, got.size(), ys.size());
      end
      for (int o = 0; o < got.size() && o < ys.size(); o++) begin
        vectors++;
        if (got[o] !== ys[o]) begin
          miscompares++;
          $display("FAIL random%0d_y[%0d]: got %0d, required %0d", j, o, got[o], ys[o]);
        end
      end
    end
  endtask

  task automatic test_m_eq_n();
    int words[$];
    int base, budget;
    for (int i = 0; i < M2; i++) words.push_back(1);
    for (int i = 5; i <= 8; i++) words.push_back(i);
    base = got2_q.size();
    bus2.m_ready = 1'b1;
    load_words(words, 0, 1'b1);
    budget = 0;
    while (got2_q.size() < base + 1 && budget < 100) begin @(posedge clk); #1; budget++; end
    repeat (20) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (got2_q.size() != base + 1) begin
      miscompares++;
      $display("FAIL meqn_count: got %0d outputs, required 1", got2_q.size() - base);
    end
    vectors++;
    if (got2_q.size() > base && got2_q[base] !== y_t'(26)) begin
      miscompares++;
      $display("FAIL meqn_y: got %0d, required 26", got2_q[base]);
    end
    vectors++;
    if (bus2.s_ready !== 1'b1 || busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL meqn_idle: s_ready=%b busy=%b, required 1 0", bus2.s_ready, busy2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_backpressure();
    test_gaps();
    test_reset_mid_issue();
    test_random();
    test_m_eq_n();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/conv1d_mac_ctrl.md
Name: conv1d_mac_ctrl

Overview:
- Sequencer that runs a 1-D valid-mode convolution on one shared part3_mac instance.
- Loads M signed filter weights, then N signed samples, from one input stream.
- For each output position it clears the MAC, issues M (x, w) pairs, waits for the result and emits y[o] on a ready/valid output stream.
- Sits between the stream front-end and the MAC; the MAC's clk, reset, a, b, valid_in, f and valid_out connect directly to the mac_* ports.

Parameters:
- N, 8, input vector length (samples per job); 2..64.
- M, 3, filter taps; 1..N.
- DW, 14, sample/weight width (signed).
- AW, 28, MAC accumulator width (signed), 2*DW.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- s_data  in  DW  signed weight/sample word.
- s_valid  in  1  s_data valid.
- s_ready  out  1  controller accepts s_data.
- m_data  out  AW  signed convolution result y[o].
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts m_data.
- mac_reset  out  1  active-high clear to MAC.
- mac_a  out  DW  sample operand to MAC.
- mac_b  out  DW  weight operand to MAC.
- mac_valid_in  out  1  operand pair valid.
- mac_f  in  AW  MAC accumulator.
- mac_valid_out  in  1  MAC accepted-product strobe (1 cycle after valid_in).
- busy  out  1  high in any state except LOAD_W with zero words loaded.

Behaviour:
- Reset (reset==0 at posedge):
  - State goes to LOAD_W; all counters cleared.
  - s_ready=0, m_valid=0, m_data=0, mac_valid_in=0, mac_a=0, mac_b=0, busy=0.
  - mac_reset=1 while reset is low.
  - Reset overrides every other event, including mid-ISSUE or an OUTPUT stall.
- States: LOAD_W -> LOAD_X -> CLEAR -> ISSUE -> DRAIN -> OUTPUT -> (CLEAR or LOAD_W).
- LOAD_W:
  - s_ready=1; each s_valid&&s_ready cycle writes w[wc], wc++.
  - After the M-th word, go to LOAD_X.
- LOAD_X:
  - Same as LOAD_W, writing x[xc], xc++.
  - After the N-th word, go to CLEAR with o=0.
  - s_ready=0 in every state other than LOAD_W and LOAD_X.
- CLEAR:
  - One cycle; mac_reset=1, mac_valid_in=0; k=0, rc=0.
  - Next state ISSUE.
- ISSUE:
  - Exactly M consecutive cycles; mac_valid_in=1, mac_a=x[o+k], mac_b=w[k]; k++.
  - After k==M-1, go to DRAIN.
  - No bubbles; operands come from registers, so there is no stall.
- rc counter: counts mac_valid_out pulses seen in ISSUE/DRAIN.
- DRAIN:
  - mac_valid_in=0; wait until rc==M.
  - On the cycle the M-th mac_valid_out is seen, register m_data<=mac_f and go to OUTPUT.
  - With a 1-cycle MAC, DRAIN lasts 1 cycle.
- OUTPUT:
  - m_valid=1; m_data held stable until m_valid&&m_ready.
  - On handshake: m_valid=0 next cycle, o++.
  - If o==N-M (last output), go to LOAD_W; otherwise go to CLEAR.
- Per-job totals: N-M+1 outputs.
- Per-output latency, CLEAR entry to m_valid: 1 + M + 1 + 1 cycles with m_ready held high. Default is 6 cycles.
- Arithmetic:
  - The controller does no arithmetic on data; y[o] = sum over k of x[o+k]*w[k].
  - y[o] is exactly as the MAC produces it; AW overflow wraps in the MAC, with no saturation here.
- Boundaries:
  - s_valid low during load: hold state and counters.
  - m_ready low: stall indefinitely in OUTPUT; MAC idle; s_ready=0.
  - M==N: one output, then LOAD_W.
  - Extra mac_valid_out pulses outside ISSUE/DRAIN are ignored.
- Weights are reloaded for every job (no retention across jobs).

Optional Feature:
- Macro: CONV_RELU_EN.
- Defined: on capture in DRAIN, m_data <= (mac_f < 0) ? 0 : mac_f.
- Undefined: m_data <= mac_f unmodified.
- Timing, latency and handshakes are identical either way.

Test Plan:
- Basic job: N=8, M=3; stream w=1,2,3 then x=1..8; m_ready=1 -> six outputs 14,20,26,32,38,44 (6o+14), in order, each m_valid one cycle; s_ready reasserts in LOAD_W after the last output.
- Negative data: w=-1,-1,-1; x=1..8 -> outputs -6,-9,-12,-15,-18,-21 without CONV_RELU_EN; all 0 with CONV_RELU_EN.
- Backpressure: basic job with m_ready low 10 cycles at y[1] -> m_valid and m_data=20 held stable 10 cycles; mac_valid_in=0 throughout; then y[2]=26 follows normally.
- Input gaps: s_valid toggled 1,0,1,0 during load -> exactly M+N words accepted; results identical to the basic job.
- Reset mid-ISSUE: assert reset (low) 1 cycle during y[2] issue -> next cycle state LOAD_W, m_valid=0, mac_valid_in=0, busy=0; a fresh job then produces correct results.
- Edge M=N=4: w=1,1,1,1; x=5,6,7,8 -> single output 26, then LOAD_W.
